// File: rtl/line_window_gen.sv
// Streaming K x K sliding-window generator: raster pixels in, interior windows out,
// using K-1 line buffers instead of a full-frame store.
module line_window_gen #(
    parameter int BIT_LENGTH = 5,
    parameter int IMG_W      = 20,
    parameter int IMG_H      = 20,
    parameter int K          = 3,
    parameter int CW         = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BIT_LENGTH-1:0]         pixel_in,
    input  logic                          in_valid,
    input  logic                          in_sof,
    output logic                          in_ready,
    output logic [K*K*BIT_LENGTH-1:0]     win_data,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [CW-1:0]                 win_row,
    output logic [CW-1:0]                 win_col,
    output logic                          win_last,
    output logic                          sof_err
);

    localparam int R   = (K - 1) / 2;
    localparam int NLB = K - 1;
    localparam int AW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [CW-1:0]         r;
    logic [CW-1:0]         c;
    logic [BIT_LENGTH-1:0] lb  [NLB][IMG_W];
    logic [BIT_LENGTH-1:0] win [K][K];
    logic [BIT_LENGTH-1:0] col_v [K];
    logic [AW-1:0]         idx;
    logic                  accept;
    logic                  bad_sof;
    logic                  last_pix;
    logic                  emit;

    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;
    assign bad_sof  = in_sof && ((r != '0) || (c != '0));
    assign last_pix = (r == CW'(IMG_H - 1)) && (c == CW'(IMG_W - 1));
    assign emit     = !bad_sof && (r >= CW'(K - 1)) && (c >= CW'(K - 1));
    // A mid-frame sof pixel is stored as column 0 of the restarted frame.
    assign idx      = bad_sof ? '0 : c[AW-1:0];

    always_comb begin
        for (int i = 0; i < K; i++) begin
            col_v[i] = '0;
        end
        for (int i = 0; i < K - 1; i++) begin
            col_v[i] = lb[K-2-i][idx];
        end
        col_v[K-1] = pixel_in;
    end

    // Line buffers carry no reset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][idx] <= pixel_in;
            for (int n = 1; n < NLB; n++) begin
                lb[n][idx] <= lb[n-1][idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r         <= '0;
            c         <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            sof_err   <= 1'b0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            sof_err <= accept && bad_sof;
            if (accept) begin
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K - 1; j++) begin
                        win[i][j] <= win[i][j+1];
                    end
                    win[i][K-1] <= col_v[i];
                end

                if (bad_sof) begin
                    r <= '0;
                    c <= CW'(1);
                end else if (c == CW'(IMG_W - 1)) begin
                    c <= '0;
                    r <= last_pix ? '0 : r + CW'(1);
                end else begin
                    c <= c + CW'(1);
                end

                if (emit) begin
                    win_valid <= 1'b1;
                    win_row   <= r - CW'(R);
                    win_col   <= c - CW'(R);
                    win_last  <= last_pix;
                end else begin
                    win_valid <= 1'b0;
                end
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_row
        for (genvar gj = 0; gj < K; gj++) begin : g_col
            assign win_data[(gi*K+gj)*BIT_LENGTH +: BIT_LENGTH] = win[gi][gj];
        end
    end

endmodule
